apb_master_arbiter: RTL and testbench
=====================================

Name: apb_master_arbiter

Overview:
- Shares one APB master port between two independent requesters, e.g. the AHB-to-APB bridge path and a DMA/config engine.
- Arbitrates round-robin and sequences APB SETUP/ACCESS phases with PREADY wait states.
- Returns read data and error status to the winning requester.
- Aborts stalled transfers with a timeout.

Parameters:
- ADDR_WIDTH, 32, address width of requesters and PADDR.
- DATA_WIDTH, 32, data width of WDATA/RDATA/PWDATA/PRDATA.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles with PREADY low before abort; 0 disables timeout.

Ports:
- HCLK  in  1  single clock for all logic
- HRESETn  in  1  asynchronous active-low reset
- REQ0, REQ1  in  1 each  transfer request, held high until matching DONE
- ADDR0, ADDR1  in  ADDR_WIDTH each  transfer address
- WRITE0, WRITE1  in  1 each  1 = write, 0 = read
- WDATA0, WDATA1  in  DATA_WIDTH each  write data
- GNT0, GNT1  out  1 each  high while that requester owns the APB bus
- DONE0, DONE1  out  1 each  one-cycle completion pulse
- RDATA  out  DATA_WIDTH  read data, valid with DONE
- ERR  out  1  PSLVERR or timeout, valid with DONE
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  ADDR_WIDTH  APB address
- PWDATA  out  DATA_WIDTH  APB write data
- PRDATA  in  DATA_WIDTH  APB read data
- PREADY, PSLVERR  in  1 each  APB completion and error

Behaviour:
- Reset (async, HRESETn low): state IDLE; all outputs 0; last_grant = 1 so requester 0 wins first; timeout counter 0.
- Reset mid-transfer drops PSEL/PENABLE immediately. No DONE is issued for the aborted transfer.
- All outputs are registered.
- State machine IDLE -> SETUP -> ACCESS -> COMPLETE -> IDLE.
- IDLE:
  - If any REQ is high, arbitrate and latch the winner's ADDR/WRITE/WDATA into PADDR/PWRITE/PWDATA. PWDATA is latched even on reads.
  - On the same edge, set GNTx=1 and PSEL=1 with PENABLE=0, then go to SETUP.
- Arbitration:
  - Only one requester high: that one wins.
  - Both high: the one not equal to last_grant wins.
  - last_grant updates at grant time.
- SETUP: go to ACCESS unconditionally; PENABLE<=1.
- ACCESS, PREADY=1:
  - Capture RDATA<=PRDATA on reads. On writes RDATA<=0.
  - ERR<=PSLVERR; pulse DONEx<=1.
  - PSEL<=0, PENABLE<=0, GNTx<=0; go to COMPLETE.
- ACCESS, PREADY=0: increment the timeout counter.
  - If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1 with PREADY still 0: abort.
  - Abort: RDATA<=0, ERR<=1, DONEx pulse, PSEL/PENABLE/GNT cleared, go to COMPLETE.
  - Counter clears on leaving ACCESS.
- COMPLETE:
  - DONEx<=0 and return to IDLE.
  - REQ sampling resumes in IDLE, so minimum spacing is one idle cycle. A requester that drops REQ in the DONE cycle is not re-granted.
- Latency: REQ high at edge N gives PSEL at N+1 and PENABLE at N+2. With zero wait states, DONE is high in cycle N+3.
- Request fields need only be stable in the cycle REQ is sampled in IDLE.
- REQ deasserted mid-transfer is ignored; the transfer completes and DONE still pulses.
- PADDR/PWRITE/PWDATA hold their last values when idle. RDATA/ERR hold until the next DONE.
- Counter width: $clog2(TIMEOUT_CYCLES+1); minimum 1.

Test Plan:
- Single read, REQ0=1 at edge 0, ADDR0=0x40, WRITE0=0, PREADY=1, PRDATA=0xDEADBEEF -> PSEL=1 at cycle 1 and PENABLE=1 at cycle 2. DONE0=1 at cycle 3 with RDATA=0xDEADBEEF, ERR=0. GNT1 never asserted.
- Simultaneous REQ0/REQ1 held through three transfers after reset -> grant order 0, 1, 0. Each DONE pulses exactly one cycle. PADDR matches the granted requester.
- Write from requester 1, ADDR1=0x10, WDATA1=0x1234, PREADY low for 3 ACCESS cycles -> PWRITE=1, PWDATA=0x1234 stable throughout. DONE1 comes 3 cycles later than the zero-wait case; RDATA=0, ERR=0.
- Slave error: PREADY=1 with PSLVERR=1 on a read -> DONE0=1, ERR=1, RDATA=PRDATA.
- Timeout, TIMEOUT_CYCLES=4, PREADY held 0 -> after 4 ACCESS cycles DONE0=1, ERR=1, RDATA=0, PSEL=0. Next request proceeds normally.
- HRESETn low during ACCESS -> all outputs 0 asynchronously and no DONE. After release, REQ1 alone is granted and completes normally.

Source files
------------

// File: rtl/apb_master_arbiter.sv
// Two-requester round-robin arbiter driving a single APB master port.
// Sequences SETUP/ACCESS with wait states and aborts ACCESS phases that stall too long.
module apb_master_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  REQ0,
  input  logic                  REQ1,
  input  logic [ADDR_WIDTH-1:0] ADDR0,
  input  logic [ADDR_WIDTH-1:0] ADDR1,
  input  logic                  WRITE0,
  input  logic                  WRITE1,
  input  logic [DATA_WIDTH-1:0] WDATA0,
  input  logic [DATA_WIDTH-1:0] WDATA1,
  output logic                  GNT0,
  output logic                  GNT1,
  output logic                  DONE0,
  output logic                  DONE1,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic                  ERR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    COMPLETE
  } state_t;

  state_t                state_q;
  logic                  lastGrant_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  gnt0_q, gnt1_q, done0_q, done1_q;
  logic                  err_q, psel_q, penable_q, pwrite_q;
  logic [DATA_WIDTH-1:0] rdata_q, pwdata_q;
  logic [ADDR_WIDTH-1:0] paddr_q;

  logic win_d;
  logic anyReq;
  logic timeoutHit;

  // When both request, the requester that did not win last time takes the bus.
  always_comb begin
    anyReq = REQ0 | REQ1;
    win_d  = 1'b0;
    if (REQ0 && REQ1) begin
      win_d = ~lastGrant_q;
    end else if (REQ1) begin
      win_d = 1'b1;
    end
    timeoutHit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      cnt_q       <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      err_q       <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      rdata_q     <= '0;
      pwdata_q    <= '0;
      paddr_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (anyReq) begin
            lastGrant_q <= win_d;
            gnt0_q      <= ~win_d;
            gnt1_q      <= win_d;
            psel_q      <= 1'b1;
            penable_q   <= 1'b0;
            paddr_q     <= win_d ? ADDR1  : ADDR0;
            pwrite_q    <= win_d ? WRITE1 : WRITE0;
            pwdata_q    <= win_d ? WDATA1 : WDATA0;
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY || timeoutHit) begin
            // A timeout abort reports as an error with zeroed read data.
            rdata_q   <= (PREADY && !pwrite_q) ? PRDATA : '0;
            err_q     <= PREADY ? PSLVERR : 1'b1;
            done0_q   <= ~lastGrant_q;
            done1_q   <= lastGrant_q;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            cnt_q     <= '0;
            state_q   <= COMPLETE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        COMPLETE: begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign GNT0    = gnt0_q;
  assign GNT1    = gnt1_q;
  assign DONE0   = done0_q;
  assign DONE1   = done1_q;
  assign RDATA   = rdata_q;
  assign ERR     = err_q;
  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed self-checking bench for apb_master_arbiter, built with a 4-cycle timeout.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_apb_master_arbiter;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        REQ0, REQ1, WRITE0, WRITE1;
  logic [31:0] ADDR0, ADDR1, WDATA0, WDATA1;
  logic        GNT0, GNT1, DONE0, DONE1, ERR, PSEL, PENABLE, PWRITE;
  logic [31:0] RDATA, PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;

  int cmpCount  = 0;
  int failCount = 0;

  apb_master_arbiter #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .REQ0   (REQ0),
    .REQ1   (REQ1),
    .ADDR0  (ADDR0),
    .ADDR1  (ADDR1),
    .WRITE0 (WRITE0),
    .WRITE1 (WRITE1),
    .WDATA0 (WDATA0),
    .WDATA1 (WDATA1),
    .GNT0   (GNT0),
    .GNT1   (GNT1),
    .DONE0  (DONE0),
    .DONE1  (DONE1),
    .RDATA  (RDATA),
    .ERR    (ERR),
    .PSEL   (PSEL),
    .PENABLE(PENABLE),
    .PWRITE (PWRITE),
    .PADDR  (PADDR),
    .PWDATA (PWDATA),
    .PRDATA (PRDATA),
    .PREADY (PREADY),
    .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic doReset();
    HRESETn = 1'b0;
    tick();
    tick();
    HRESETn = 1'b1;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    REQ0 = 0; REQ1 = 0; WRITE0 = 0; WRITE1 = 0;
    ADDR0 = 0; ADDR1 = 0; WDATA0 = 0; WDATA1 = 0;
    PRDATA = 0; PREADY = 0; PSLVERR = 0;
    tick();
    tick();
    cmpCount++; if ({GNT0, GNT1, DONE0, DONE1, ERR, PSEL, PENABLE, PWRITE} !== 8'h00) begin failCount++; $display("[TB] FAIL reset_ctrl: got %b want 00000000", {GNT0, GNT1, DONE0, DONE1, ERR, PSEL, PENABLE, PWRITE}); end
    cmpCount++; if ({RDATA, PADDR, PWDATA} !== 96'h0) begin failCount++; $display("[TB] FAIL reset_data: got %h want 0", {RDATA, PADDR, PWDATA}); end
    HRESETn = 1'b1;
    tick();
    cmpCount++; if ({GNT0, GNT1, PSEL} !== 3'b000) begin failCount++; $display("[TB] FAIL idle_no_req: got %b want 000", {GNT0, GNT1, PSEL}); end
  endtask

  task automatic test_single_read();
    logic gnt1Seen;
    gnt1Seen = 1'b0;
    REQ0 = 1; ADDR0 = 32'h40; WRITE0 = 0; PREADY = 1; PRDATA = 32'hDEADBEEF;
    tick();
    gnt1Seen |= GNT1;
    cmpCount++; if ({PSEL, PENABLE, GNT0} !== 3'b101) begin failCount++; $display("[TB] FAIL read_setup: got %b want 101", {PSEL, PENABLE, GNT0}); end
    cmpCount++; if (PADDR !== 32'h40) begin failCount++; $display("[TB] FAIL read_paddr: got %h want 00000040", PADDR); end
    tick();
    gnt1Seen |= GNT1;
    cmpCount++; if ({PSEL, PENABLE, DONE0} !== 3'b110) begin failCount++; $display("[TB] FAIL read_access: got %b want 110", {PSEL, PENABLE, DONE0}); end
    tick();
    gnt1Seen |= GNT1;
    cmpCount++; if ({DONE0, ERR, PSEL, GNT0} !== 4'b1000) begin failCount++; $display("[TB] FAIL read_done: got %b want 1000", {DONE0, ERR, PSEL, GNT0}); end
    cmpCount++; if (RDATA !== 32'hDEADBEEF) begin failCount++; $display("[TB] FAIL read_rdata: got %h want deadbeef", RDATA); end
    REQ0 = 0;
    tick();
    gnt1Seen |= GNT1;
    cmpCount++; if (DONE0 !== 1'b0) begin failCount++; $display("[TB] FAIL read_done_pulse: got %b want 0", DONE0); end
    tick();
    gnt1Seen |= GNT1;
    cmpCount++; if ({gnt1Seen, GNT0, PSEL} !== 3'b000) begin failCount++; $display("[TB] FAIL read_no_regrant: got %b want 000", {gnt1Seen, GNT0, PSEL}); end
  endtask

  task automatic test_round_robin();
    logic        expOwner;
    logic [31:0] expAddr;
    doReset();
    REQ0 = 1; REQ1 = 1; WRITE0 = 0; WRITE1 = 0;
    ADDR0 = 32'h100; ADDR1 = 32'h200; PREADY = 1;
    for (int i = 0; i < 3; i++) begin
      expOwner = (i == 1);
      expAddr  = expOwner ? 32'h200 : 32'h100;
      PRDATA   = 32'hA0 + i;
      tick();
      cmpCount++; if ({GNT0, GNT1} !== {~expOwner, expOwner}) begin failCount++; $display("[TB] FAIL rr_grant%0d: got %b want %b", i, {GNT0, GNT1}, {~expOwner, expOwner}); end
      cmpCount++; if (PADDR !== expAddr) begin failCount++; $display("[TB] FAIL rr_paddr%0d: got %h want %h", i, PADDR, expAddr); end
      tick();
      cmpCount++; if ({DONE0, DONE1} !== 2'b00) begin failCount++; $display("[TB] FAIL rr_early_done%0d: got %b want 00", i, {DONE0, DONE1}); end
      tick();
      cmpCount++; if ({DONE0, DONE1} !== {~expOwner, expOwner}) begin failCount++; $display("[TB] FAIL rr_done%0d: got %b want %b", i, {DONE0, DONE1}, {~expOwner, expOwner}); end
      cmpCount++; if (RDATA !== 32'hA0 + i) begin failCount++; $display("[TB] FAIL rr_rdata%0d: got %h want %h", i, RDATA, 32'hA0 + i); end
      tick();
      cmpCount++; if ({DONE0, DONE1} !== 2'b00) begin failCount++; $display("[TB] FAIL rr_done_pulse%0d: got %b want 00", i, {DONE0, DONE1}); end
    end
    REQ0 = 0; REQ1 = 0;
    tick();
  endtask

  task automatic test_wait_write();
    REQ1 = 1; ADDR1 = 32'h10; WRITE1 = 1; WDATA1 = 32'h1234; PREADY = 0; PRDATA = 32'hCAFEF00D;
    tick();
    cmpCount++; if ({GNT1, PSEL, PWRITE} !== 3'b111) begin failCount++; $display("[TB] FAIL wr_grant: got %b want 111", {GNT1, PSEL, PWRITE}); end
    cmpCount++; if ({PADDR, PWDATA} !== {32'h10, 32'h1234}) begin failCount++; $display("[TB] FAIL wr_fields: got %h want 0000001000001234", {PADDR, PWDATA}); end
    ADDR1 = 32'h99; WDATA1 = 32'hFFFF;
    tick();
    for (int i = 0; i < 3; i++) begin
      cmpCount++; if ({PENABLE, PWRITE, DONE1, PWDATA} !== {3'b110, 32'h1234}) begin failCount++; $display("[TB] FAIL wr_wait%0d: got %b/%h want 110/00001234", i, {PENABLE, PWRITE, DONE1}, PWDATA); end
      tick();
    end
    PREADY = 1;
    tick();
    cmpCount++; if ({DONE1, ERR, RDATA} !== {2'b10, 32'h0}) begin failCount++; $display("[TB] FAIL wr_done: got %b/%h want 10/00000000", {DONE1, ERR}, RDATA); end
    REQ1 = 0; WRITE1 = 0;
    tick();
    tick();
  endtask

  task automatic test_slave_error();
    REQ0 = 1; ADDR0 = 32'h44; WRITE0 = 0; PREADY = 1; PSLVERR = 1; PRDATA = 32'h5A5A0001;
    tick();
    tick();
    tick();
    cmpCount++; if ({DONE0, ERR, RDATA} !== {2'b11, 32'h5A5A0001}) begin failCount++; $display("[TB] FAIL slverr: got %b/%h want 11/5a5a0001", {DONE0, ERR}, RDATA); end
    REQ0 = 0; PSLVERR = 0;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    REQ0 = 1; ADDR0 = 32'h48; WRITE0 = 0; PREADY = 0; PRDATA = 32'h77;
    tick();
    tick();
    tick();
    tick();
    tick();
    cmpCount++; if ({PSEL, PENABLE, DONE0} !== 3'b110) begin failCount++; $display("[TB] FAIL to_before: got %b want 110", {PSEL, PENABLE, DONE0}); end
    tick();
    cmpCount++; if ({DONE0, ERR, PSEL, GNT0, RDATA} !== {4'b1100, 32'h0}) begin failCount++; $display("[TB] FAIL to_abort: got %b/%h want 1100/00000000", {DONE0, ERR, PSEL, GNT0}, RDATA); end
    REQ0 = 0;
    tick();
    tick();
    REQ0 = 1;
    tick();
    tick();
    tick();
    tick();
    tick();
    PREADY = 1;
    tick();
    cmpCount++; if ({DONE0, ERR, RDATA} !== {2'b10, 32'h77}) begin failCount++; $display("[TB] FAIL to_recover: got %b/%h want 10/00000077", {DONE0, ERR}, RDATA); end
    REQ0 = 0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    logic done0Seen;
    REQ0 = 1; ADDR0 = 32'h50; WRITE0 = 0; PREADY = 0;
    tick();
    tick();
    #3;
    HRESETn = 1'b0;
    #1;
    cmpCount++; if ({GNT0, PSEL, PENABLE, DONE0, PADDR} !== {4'b0000, 32'h0}) begin failCount++; $display("[TB] FAIL rst_async: got %b/%h want 0000/00000000", {GNT0, PSEL, PENABLE, DONE0}, PADDR); end
    PREADY = 1;
    tick();
    done0Seen = DONE0;
    tick();
    done0Seen |= DONE0;
    HRESETn = 1'b1;
    REQ0 = 0; REQ1 = 1; ADDR1 = 32'h20; WRITE1 = 0; PRDATA = 32'h11;
    tick();
    done0Seen |= DONE0;
    cmpCount++; if ({GNT0, GNT1, PADDR} !== {2'b01, 32'h20}) begin failCount++; $display("[TB] FAIL rst_regrant: got %b/%h want 01/00000020", {GNT0, GNT1}, PADDR); end
    tick();
    done0Seen |= DONE0;
    tick();
    done0Seen |= DONE0;
    cmpCount++; if ({DONE1, ERR, RDATA} !== {2'b10, 32'h11}) begin failCount++; $display("[TB] FAIL rst_complete: got %b/%h want 10/00000011", {DONE1, ERR}, RDATA); end
    cmpCount++; if (done0Seen !== 1'b0) begin failCount++; $display("[TB] FAIL rst_no_done0: got %b want 0", done0Seen); end
    REQ1 = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_wait_write();
    test_slave_error();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got time limit reached want completion");
    $fatal(1, "[TB] simulation time limit");
  end

endmodule
